sprite_sched: RTL

SPRITE_SCHED -- requirements
Module: sprite_sched

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_slot_regs.sv | 30 +++
 rtl/sprite_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite scheduler: slot-entry layout, field widths and
// scheduler states.
package sprite_pkg;

  localparam int unsigned TABLE_W = 3;
  localparam int unsigned NUM_W   = 9;
  localparam int unsigned POS_W   = 9;

  // 'table' is a reserved word, hence 'tbl'
  typedef struct packed {
    logic               valid;
    logic [TABLE_W-1:0] tbl;
    logic [NUM_W-1:0]   number;
    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
  } slot_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sprite_slot_regs.sv
// Object slot storage: one synchronous write port and one combinational read
// port.
module sprite_slot_regs
  import sprite_pkg::*;
#(
  parameter int unsigned NSLOTS = 8,
  localparam int unsigned SLOT_W = $clog2(NSLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SLOT_W-1:0] wr_slot,
  input  slot_entry_t       wr_data,
  input  logic [SLOT_W-1:0] rd_slot,
  output slot_entry_t       rd_data
);

  slot_entry_t slots [NSLOTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSLOTS; i++) slots[i] <= '0;
    end else if (we) begin
      slots[wr_slot] <= wr_data;
    end
  end

  assign rd_data = slots[rd_slot];

endmodule

// File: rtl/sprite_sched.sv
// Sprite scheduler: sweeps all slots through a shared generator, one slot per
// cycle, and reports the lowest-numbered hit. SPRITE_COLLISION_EN adds collide/hit_mask.
module sprite_sched
  import sprite_pkg::*;
#(
  parameter int unsigned NSLOTS = 8,
  localparam int unsigned SLOT_W = $clog2(NSLOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  output logic               wr_ready,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic               wr_valid,
  input  logic [TABLE_W-1:0] wr_table,
  input  logic [NUM_W-1:0]   wr_number,
  input  logic [POS_W-1:0]   wr_x,
  input  logic [POS_W-1:0]   wr_y,
  input  logic               pix_stb,
  input  logic [POS_W-1:0]   h_pos,
  input  logic [POS_W-1:0]   v_pos,
  output logic [TABLE_W-1:0] gen_table,
  output logic [NUM_W-1:0]   gen_number,
  output logic [POS_W-1:0]   gen_x,
  output logic [POS_W-1:0]   gen_y,
  output logic [POS_W-1:0]   gen_h,
  output logic [POS_W-1:0]   gen_v,
  input  logic               gen_state,
  output logic               res_valid,
  output logic               res_on,
  output logic [SLOT_W-1:0]  res_slot,
  output logic               overrun
`ifdef SPRITE_COLLISION_EN
  ,
  output logic               collide,
  output logic [NSLOTS-1:0]  hit_mask
`endif
);

  sched_state_t      state;
  logic [SLOT_W-1:0] idx;
  logic              hit_found;
  logic [SLOT_W-1:0] hit_slot;
  slot_entry_t       wr_data;
  slot_entry_t       cur;
  logic              last_slot;
  logic              cur_hit;
  logic              found_nx;
  logic [SLOT_W-1:0] slot_nx;

  assign wr_ready = (state == ST_IDLE);
  assign wr_data  = '{valid: wr_valid, tbl: wr_table, number: wr_number, x: wr_x, y: wr_y};

  sprite_slot_regs #(.NSLOTS(NSLOTS)) u_slots (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en && wr_ready),
    .wr_slot (wr_slot),
    .wr_data (wr_data),
    .rd_slot (idx),
    .rd_data (cur)
  );

  assign gen_table  = cur.tbl;
  assign gen_number = cur.number;
  assign gen_x      = cur.x;
  assign gen_y      = cur.y;
  assign res_valid  = (state == ST_DONE);

  assign last_slot = (idx == SLOT_W'(NSLOTS - 1));
  assign cur_hit   = (state == ST_SCAN) && cur.valid && gen_state;

  // Merge this cycle's sample so the final slot's hit lands in the result
  always_comb begin
    found_nx = hit_found || cur_hit;
    slot_nx  = '0;
    if (hit_found) slot_nx = hit_slot;
    else if (cur_hit) slot_nx = idx;
  end

`ifdef SPRITE_COLLISION_EN
  logic [NSLOTS-1:0] mask_acc;
  logic [NSLOTS-1:0] mask_nx;

  assign mask_nx = mask_acc | (cur_hit ? (NSLOTS'(1) << idx) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_acc <= '0;
      hit_mask <= '0;
      collide  <= 1'b0;
    end else if (state == ST_IDLE && pix_stb) begin
      mask_acc <= '0;
    end else if (state == ST_SCAN) begin
      mask_acc <= mask_nx;
      if (last_slot) begin
        hit_mask <= mask_nx;
        collide  <= |(mask_nx & (mask_nx - 1'b1));
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      gen_h     <= '0;
      gen_v     <= '0;
      hit_found <= 1'b0;
      hit_slot  <= '0;
      res_on    <= 1'b0;
      res_slot  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (pix_stb && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pix_stb) begin
            gen_h     <= h_pos;
            gen_v     <= v_pos;
            hit_found <= 1'b0;
            hit_slot  <= '0;
            idx       <= '0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          hit_found <= found_nx;
          hit_slot  <= slot_nx;
          idx       <= idx + 1'b1;
          if (last_slot) begin
            res_on   <= found_nx;
            res_slot <= slot_nx;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
